// File: rtl/sd_card_responder.sv
// SPI-mode SD card responder: answers CMD0, CMD1 and CMD17 single-block reads
// from a byte memory, so a host-side sector reader can be exercised without a card.
//
// state      | meaning
// -----------+---------------------------------------------------------------
// WAIT_CMD   | idle, sending 0xFF, looking for a 01xxxxxx command byte
// GET_ARG    | receiving 4 argument bytes then the (unchecked) CRC byte
// NCR        | sending NCR_BYTES filler bytes of 0xFF
// R1         | sending the R1 response byte
// TOKEN_WAIT | CMD17 only: sending TOKEN_DELAY filler bytes of 0xFF
// TOKEN      | CMD17 only: sending 0xFE, byte 0 of the block is fetched
// DATA       | CMD17 only: sending 512 data bytes, next byte prefetched
// CRC        | CMD17 only: sending two 0xFF CRC bytes, then block counted

module sd_card_responder #(
    parameter int INIT_POLLS  = 2,
    parameter int NCR_BYTES   = 1,
    parameter int TOKEN_DELAY = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        spi_cs,
    input  logic        spi_clk,
    input  logic        spi_di,
    output logic        spi_do,
    output logic [23:0] mem_address,
    output logic        mem_read,
    input  logic [7:0]  mem_data,
    output logic        in_idle,
    output logic        busy,
    output logic [7:0]  sector_count
);

    typedef enum logic [2:0] {
        WAIT_CMD,
        GET_ARG,
        NCR,
        R1,
        TOKEN_WAIT,
        TOKEN,
        DATA,
        CRC
    } state_t;

    localparam logic [8:0] NCR_LAST   = 9'(NCR_BYTES - 1);
    localparam logic [8:0] TOKEN_LAST = 9'((TOKEN_DELAY > 0) ? (TOKEN_DELAY - 1) : 0);
    localparam logic [7:0] POLLS_INIT = 8'(INIT_POLLS);

    state_t      state, state_n;

    logic [1:0]  cs_sync, sclk_sync, di_sync;
    logic        cs_prev, sclk_prev;
    logic        cs_active, cs_fall, sclk_rise, sclk_fall;

    logic [2:0]  bit_cnt;
    logic [6:0]  rx_shift;
    logic [6:0]  tx_shift;
    logic        rx_done;
    logic [7:0]  rx_byte;

    logic [8:0]  cnt, cnt_n;
    logic [5:0]  cmd_idx;
    logic [14:0] arg_sector;
    logic [14:0] sector;
    logic [7:0]  r1_val;
    logic        is_read;
    logic [7:0]  poll_cnt;
    logic [7:0]  hold;
    logic        rd_pending;

    logic [7:0]  tx_next;
    logic        fetch;
    logic [8:0]  fetch_idx;
    logic        latch_cmd;
    logic        arg_byte;
    logic        eval_cmd;
    logic        clr_busy;
    logic        block_done;

    // Bring the slow SPI pins into the clk domain and remember last values for edge detection.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cs_sync   <= 2'b11;
            sclk_sync <= 2'b00;
            di_sync   <= 2'b11;
            cs_prev   <= 1'b1;
            sclk_prev <= 1'b0;
        end else begin
            cs_sync   <= {cs_sync[0], spi_cs};
            sclk_sync <= {sclk_sync[0], spi_clk};
            di_sync   <= {di_sync[0], spi_di};
            cs_prev   <= cs_sync[1];
            sclk_prev <= sclk_sync[1];
        end
    end

    assign cs_active = ~cs_sync[1];
    assign cs_fall   = ~cs_sync[1] & cs_prev;
    assign sclk_rise = cs_active & sclk_sync[1] & ~sclk_prev;
    assign sclk_fall = cs_active & ~sclk_sync[1] & sclk_prev;
    assign rx_done   = sclk_rise & (bit_cnt == 3'd7);
    assign rx_byte   = {rx_shift, di_sync[1]};

    // Byte engine: sample MOSI on rising edges, shift MISO on falling edges,
    // and load the next transmit byte at each byte boundary so its MSB is ready early.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bit_cnt  <= 3'd0;
            rx_shift <= 7'd0;
            tx_shift <= 7'h7F;
            spi_do   <= 1'b1;
        end else if (!cs_active) begin
            bit_cnt  <= 3'd0;
            tx_shift <= 7'h7F;
            spi_do   <= 1'b1;
        end else begin
            if (cs_fall) begin
                tx_shift <= 7'h7F;
                spi_do   <= 1'b1;
            end
            if (sclk_rise) begin
                rx_shift <= rx_byte[6:0];
                bit_cnt  <= bit_cnt + 3'd1;
                if (rx_done) begin
                    tx_shift <= tx_next[6:0];
                    spi_do   <= tx_next[7];
                end
            end else if (sclk_fall && bit_cnt != 3'd0) begin
                spi_do   <= tx_shift[6];
                tx_shift <= {tx_shift[5:0], 1'b1};
            end
        end
    end

    // Parser state register; chip select high always abandons the transaction.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= WAIT_CMD;
        end else if (!cs_active) begin
            state <= WAIT_CMD;
        end else begin
            state <= state_n;
        end
    end

    // Next state, next transmit byte and datapath strobes, evaluated at byte boundaries.
    always_comb begin
        state_n    = state;
        cnt_n      = cnt;
        tx_next    = 8'hFF;
        fetch      = 1'b0;
        fetch_idx  = 9'd0;
        latch_cmd  = 1'b0;
        arg_byte   = 1'b0;
        eval_cmd   = 1'b0;
        clr_busy   = 1'b0;
        block_done = 1'b0;
        if (rx_done) begin
            case (state)
                WAIT_CMD: begin
                    if (rx_byte[7:6] == 2'b01) begin
                        latch_cmd = 1'b1;
                        cnt_n     = 9'd0;
                        state_n   = GET_ARG;
                    end
                end
                GET_ARG: begin
                    if (cnt == 9'd4) begin
                        eval_cmd = 1'b1;
                        cnt_n    = 9'd0;
                        state_n  = NCR;
                    end else begin
                        arg_byte = 1'b1;
                        cnt_n    = cnt + 9'd1;
                    end
                end
                NCR: begin
                    if (cnt == NCR_LAST) begin
                        cnt_n   = 9'd0;
                        tx_next = r1_val;
                        state_n = R1;
                    end else begin
                        cnt_n = cnt + 9'd1;
                    end
                end
                R1: begin
                    if (!is_read) begin
                        clr_busy = 1'b1;
                        state_n  = WAIT_CMD;
                    end else if (TOKEN_DELAY == 0) begin
                        tx_next = 8'hFE;
                        fetch   = 1'b1;
                        state_n = TOKEN;
                    end else begin
                        cnt_n   = 9'd0;
                        state_n = TOKEN_WAIT;
                    end
                end
                TOKEN_WAIT: begin
                    if (cnt == TOKEN_LAST) begin
                        tx_next = 8'hFE;
                        fetch   = 1'b1;
                        state_n = TOKEN;
                    end else begin
                        cnt_n = cnt + 9'd1;
                    end
                end
                TOKEN: begin
                    tx_next   = hold;
                    fetch     = 1'b1;
                    fetch_idx = 9'd1;
                    cnt_n     = 9'd0;
                    state_n   = DATA;
                end
                DATA: begin
                    if (cnt == 9'd511) begin
                        cnt_n   = 9'd0;
                        state_n = CRC;
                    end else begin
                        tx_next = hold;
                        cnt_n   = cnt + 9'd1;
                        if (cnt != 9'd510) begin
                            fetch     = 1'b1;
                            fetch_idx = cnt + 9'd2;
                        end
                    end
                end
                CRC: begin
                    if (cnt == 9'd1) begin
                        clr_busy   = 1'b1;
                        block_done = 1'b1;
                        state_n    = WAIT_CMD;
                    end else begin
                        cnt_n = cnt + 9'd1;
                    end
                end
                default: state_n = WAIT_CMD;
            endcase
        end
    end

    // Command bookkeeping: argument capture, R1 decision, idle flag, poll counter, block count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt          <= 9'd0;
            cmd_idx      <= 6'd0;
            arg_sector   <= 15'd0;
            sector       <= 15'd0;
            r1_val       <= 8'hFF;
            is_read      <= 1'b0;
            in_idle      <= 1'b1;
            poll_cnt     <= POLLS_INIT;
            busy         <= 1'b0;
            sector_count <= 8'd0;
        end else if (!cs_active) begin
            cnt     <= 9'd0;
            is_read <= 1'b0;
            busy    <= 1'b0;
        end else begin
            cnt <= cnt_n;
            if (latch_cmd) begin
                cmd_idx <= rx_byte[5:0];
            end
            // Only arg[23:9] matters: it spans the second and third argument bytes.
            if (arg_byte) begin
                if (cnt == 9'd1) begin
                    arg_sector[14:7] <= rx_byte;
                end else if (cnt == 9'd2) begin
                    arg_sector[6:0] <= rx_byte[7:1];
                end
            end
            if (eval_cmd) begin
                busy    <= 1'b1;
                is_read <= 1'b0;
                case (cmd_idx)
                    6'd0: begin
                        r1_val   <= 8'h01;
                        in_idle  <= 1'b1;
                        poll_cnt <= POLLS_INIT;
                    end
                    6'd1: begin
                        if (in_idle && poll_cnt != 8'd0) begin
                            r1_val   <= 8'h01;
                            poll_cnt <= poll_cnt - 8'd1;
                        end else begin
                            r1_val  <= 8'h00;
                            in_idle <= 1'b0;
                        end
                    end
                    6'd17: begin
                        if (in_idle) begin
                            r1_val <= 8'h05;
                        end else begin
                            r1_val  <= 8'h00;
                            sector  <= arg_sector;
                            is_read <= 1'b1;
                        end
                    end
                    default: r1_val <= {7'b0000010, in_idle};
                endcase
            end
            if (clr_busy) begin
                busy <= 1'b0;
            end
            if (block_done) begin
                sector_count <= sector_count + 8'd1;
            end
        end
    end

    // Memory prefetch: one-clk strobe per byte, data captured into the holding register a clk later.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_read    <= 1'b0;
            mem_address <= 24'd0;
            rd_pending  <= 1'b0;
            hold        <= 8'hFF;
        end else begin
            rd_pending <= mem_read;
            if (rd_pending) begin
                hold <= mem_data;
            end
            if (!cs_active) begin
                mem_read <= 1'b0;
            end else begin
                mem_read <= fetch;
                if (fetch) begin
                    mem_address <= {sector, fetch_idx};
                end
            end
        end
    end

endmodule
